// File: rtl/pcie_framing_pkg.sv
// Shared PCIe Gen1/Gen2 framing constants, FSM encoding and per-byte flag bundle.
// Imported by framing_byte_step and packet_identifier_lanes.
package pcie_framing_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam logic [2:0] DLLP_DATA_LEN = 3'd6;

  localparam logic [2:0] GEN1 = 3'b000;
  localparam logic [2:0] GEN2 = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TLP  = 2'd1,
    S_DLP  = 2'd2
  } fstate_t;

  typedef struct packed {
    logic valid;
    logic dlpstart;
    logic dlpend;
    logic tlpstart;
    logic tlpedb;
    logic tlpend;
    logic err;
  } byte_flags_t;

endpackage

// File: rtl/packet_identifier_lanes_step.sv
// Single-byte framing transition: one link of the per-beat carry chain.
// Pure combinational; dlp_cnt is zero whenever the next state is not DLP.
module framing_byte_step
  import pcie_framing_pkg::*;
(
  input  fstate_t     state,
  input  logic [2:0]  cnt,
  input  logic [7:0]  sym,
  input  logic        k,
  output fstate_t     next_state,
  output logic [2:0]  next_cnt,
  output byte_flags_t flags
);

  logic is_stp, is_sdp, is_end, is_edb;

  assign is_stp = k && (sym == K_STP);
  assign is_sdp = k && (sym == K_SDP);
  assign is_end = k && (sym == K_END);
  assign is_edb = k && (sym == K_EDB);

  always_comb begin
    next_state = S_IDLE;
    next_cnt   = '0;
    flags      = '0;
    case (state)
      S_IDLE: begin
        unique case (1'b1)
          is_stp: begin
            flags.tlpstart = 1'b1;
            flags.valid    = 1'b1;
            next_state     = S_TLP;
          end
          is_sdp: begin
            flags.dlpstart = 1'b1;
            flags.valid    = 1'b1;
            next_state     = S_DLP;
          end
          is_end, is_edb: flags.err = 1'b1;
          default: ;
        endcase
      end
      S_TLP: begin
        unique case (1'b1)
          !k: begin
            flags.valid = 1'b1;
            next_state  = S_TLP;
          end
          is_end: begin
            flags.tlpend = 1'b1;
            flags.valid  = 1'b1;
          end
          is_edb: begin
            flags.tlpedb = 1'b1;
            flags.valid  = 1'b1;
          end
          // Back-to-back STP restarts the TLP but is still flagged.
          is_stp: begin
            flags.err      = 1'b1;
            flags.tlpstart = 1'b1;
            flags.valid    = 1'b1;
            next_state     = S_TLP;
          end
          default: flags.err = 1'b1;
        endcase
      end
      S_DLP: begin
        if (!k) begin
          if (cnt == DLLP_DATA_LEN) begin
            flags.err = 1'b1;
          end else begin
            flags.valid = 1'b1;
            next_cnt    = cnt + 3'd1;
            next_state  = S_DLP;
          end
        end else if (is_end && cnt == DLLP_DATA_LEN) begin
          flags.dlpend = 1'b1;
          flags.valid  = 1'b1;
        end else begin
          flags.err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/packet_identifier_lanes.sv
// Gen1/Gen2 receive framing identifier over a LANES*BYTES_PER_LANE beat.
// Optional: define PACKET_ID_ERR_EN to build pl_err and err_count.
module packet_identifier_lanes
  import pcie_framing_pkg::*;
#(
  parameter  int LANES          = 16,
  parameter  int BYTES_PER_LANE = 4,
  localparam int BYTES          = LANES * BYTES_PER_LANE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTES*8-1:0] data_in,
  input  logic [BYTES-1:0]   DK,
  input  logic               valid_pd,
  input  logic               linkup,
  input  logic [2:0]         gen,
  input  logic [4:0]         numberOfDetectedLanes,
  output logic [BYTES*8-1:0] data_out,
  output logic [BYTES-1:0]   pl_valid,
  output logic [BYTES-1:0]   pl_dlpstart,
  output logic [BYTES-1:0]   pl_dlpend,
  output logic [BYTES-1:0]   pl_tlpstart,
  output logic [BYTES-1:0]   pl_tlpedb,
  output logic [BYTES-1:0]   pl_tlpend,
  output logic [BYTES-1:0]   pl_err,
  output logic [15:0]        err_count
);

  fstate_t    state_q, state_d, s_scan;
  logic [2:0] cnt_q, cnt_d, c_scan;
  logic       bypass, load, scan;
  logic [15:0] n_act;

  logic [BYTES-1:0] v_d, ds_d, de_d, ts_d, te_d, tn_d, er_d;

  assign bypass = !(gen == GEN1 || gen == GEN2);
  assign n_act  = 16'(numberOfDetectedLanes) * 16'(BYTES_PER_LANE);

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
    fstate_t     s_in, s_step, s_out;
    logic [2:0]  c_in, c_step, c_out;
    byte_flags_t f, fm;
    logic        act;

    if (gi == 0) begin : g_head
      assign s_in = state_q;
      assign c_in = cnt_q;
    end else begin : g_tail
      assign s_in = g_byte[gi-1].s_out;
      assign c_in = g_byte[gi-1].c_out;
    end

    framing_byte_step u_step (
      .state      (s_in),
      .cnt        (c_in),
      .sym        (data_in[8*gi +: 8]),
      .k          (DK[gi]),
      .next_state (s_step),
      .next_cnt   (c_step),
      .flags      (f)
    );

    // Inactive lanes pass the carry through untouched.
    assign act   = (16'(gi) < n_act);
    assign s_out = act ? s_step : s_in;
    assign c_out = act ? c_step : c_in;
    assign fm    = act ? f : '0;

    assign v_d[gi]  = fm.valid;
    assign ds_d[gi] = fm.dlpstart;
    assign de_d[gi] = fm.dlpend;
    assign ts_d[gi] = fm.tlpstart;
    assign te_d[gi] = fm.tlpedb;
    assign tn_d[gi] = fm.tlpend;
    assign er_d[gi] = fm.err;
  end

  assign s_scan = g_byte[BYTES-1].s_out;
  assign c_scan = g_byte[BYTES-1].c_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    scan    = 1'b0;
    if (!linkup || bypass) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      load    = 1'b1;
    end else if (valid_pd) begin
      state_d = s_scan;
      cnt_d   = c_scan;
      load    = 1'b1;
      scan    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_out    <= '0;
      pl_valid    <= '0;
      pl_dlpstart <= '0;
      pl_dlpend   <= '0;
      pl_tlpstart <= '0;
      pl_tlpedb   <= '0;
      pl_tlpend   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (load) data_out <= data_in;
      pl_valid    <= scan ? v_d  : '0;
      pl_dlpstart <= scan ? ds_d : '0;
      pl_dlpend   <= scan ? de_d : '0;
      pl_tlpstart <= scan ? ts_d : '0;
      pl_tlpedb   <= scan ? te_d : '0;
      pl_tlpend   <= scan ? tn_d : '0;
    end
  end

`ifdef PACKET_ID_ERR_EN
  localparam int CW = $clog2(BYTES + 1);

  logic [CW-1:0] err_pop;
  logic [16:0]   err_sum;

  always_comb begin
    err_pop = '0;
    for (int i = 0; i < BYTES; i++) err_pop += CW'(er_d[i]);
  end

  assign err_sum = {1'b0, err_count} + 17'(err_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pl_err    <= '0;
      err_count <= '0;
    end else begin
      pl_err <= scan ? er_d : '0;
      if (scan) err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`else
  logic unused_err;
  assign unused_err = ^er_d;
  assign pl_err     = '0;
  assign err_count  = '0;
`endif

endmodule

// File: doc/packet_identifier_lanes.md
# packet_identifier_lanes

Parametrised Gen1/Gen2 receive framing identifier that sits between the descrambled lane-deskew output and the data link layer. It classifies every byte of a wide symbol beat as TLP/DLLP start, end, nullified end (EDB) or payload. It carries packet state across beats so TLPs and DLLPs may span any number of cycles, and it honours the active lane count. Outputs are registered one cycle after input.

## Interface
- `LANES`, 16: maximum link width.
- `BYTES_PER_LANE`, 4: symbols per lane per beat; `BYTES = LANES*BYTES_PER_LANE` (64 by default).
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `data_in` in BYTES*8: symbol beat; byte i = `data_in[8i+7:8i]`; byte 0 is earliest on the wire.
- `DK` in BYTES: 1 = byte i is a K-symbol, 0 = data.
- `valid_pd` in 1: beat qualifier.
- `linkup` in 1: link is in L0.
- `gen` in 3: 3'b000 = Gen1, 3'b001 = Gen2; any other value selects bypass.
- `numberOfDetectedLanes` in 5: active lanes, 1..LANES; active bytes `N = numberOfDetectedLanes*BYTES_PER_LANE`.
- `data_out` out BYTES*8: registered copy of `data_in`.
- `pl_valid`, `pl_dlpstart`, `pl_dlpend`, `pl_tlpstart`, `pl_tlpedb`, `pl_tlpend` out BYTES each: per-byte flags.
- `pl_err` out BYTES: per-byte framing error.
- `err_count` out 16: saturating framing-error count.

## Operation
- K codes: STP = 8'hFB, SDP = 8'h5C, END = 8'hFD, EDB = 8'hFE. Every other K-symbol is a filler K.
- Bytes are scanned 0..N-1 in order. Bytes at N and above are ignored, and all their flags are 0.
- The state is one of IDLE, TLP or DLP, plus a 3-bit `dlp_cnt`. State carries from byte to byte and from beat to beat.
- IDLE:
  - STP: set `tlpstart` and `valid`; go to TLP.
  - SDP: set `dlpstart` and `valid`; go to DLP with `dlp_cnt` = 0.
  - END or EDB: error; stay in IDLE.
  - Data or filler K: no flags set (logical idle).
- TLP:
  - Data: set `valid`.
  - END: set `tlpend` and `valid`; go to IDLE.
  - EDB: set `tlpedb` and `valid`; go to IDLE.
  - STP: error. The byte is also treated as a new `tlpstart` and `valid`; stay in TLP.
  - SDP or filler K: error; go to IDLE.
- DLP:
  - Data: set `valid` and increment `dlp_cnt`. A 7th data byte is an error; go to IDLE.
  - END with `dlp_cnt` = 6: set `dlpend` and `valid`; go to IDLE.
  - END with any other count, or any other K: error; go to IDLE.
- `pl_valid` covers every packet byte from the start symbol through the end symbol inclusive.
- `err_count` increments by the number of error bytes in the beat and saturates at 16'hFFFF.
- `valid_pd` = 0: all flag outputs are 0 next cycle, `data_out` holds its value, and state is held.
- `linkup` = 0: state forced to IDLE and all flags are 0 next cycle. `err_count` is held.
- Bypass (`gen` not Gen1/Gen2): `data_out` follows `data_in`, all flags are 0, and state is forced to IDLE.
- A change of `numberOfDetectedLanes` takes effect on the next beat. State is not reset.

## Timing
- Latency is 1 cycle: flags for the beat presented at edge k appear after edge k+1, aligned with `data_out`.
- Reset value: all outputs 0, state IDLE, `dlp_cnt` = 0, `err_count` = 0.
- Reset asserted mid-packet: the packet is discarded. A following beat with payload but no start symbol produces no flags.
- Precedence: `reset` > `linkup` = 0 > bypass > `valid_pd` = 0 > scan.
- One beat may contain multiple starts and ends, e.g. END, SDP, 6 data, END, STP.
- The scan is a single-cycle combinational carry chain across BYTES positions. No back-pressure is applied.

## Configuration
- `PACKET_ID_ERR_EN`:
  - Defined: `pl_err` and `err_count` are implemented as described.
  - Undefined: both are tied to 0 and the counter logic is absent.
- State-transition behaviour is identical either way.

## Structure
- Package/include `pcie_framing_pkg`: K-code constants (STP/SDP/END/EDB), the state encoding, `DLLP_DATA_LEN` = 6, and the Gen1/Gen2 `gen` encodings.
- Sub-module `framing_byte_step`: combinational single-byte transition. It takes state, `dlp_cnt`, byte and K bit, and returns next state, next count and six flags plus error. It is instantiated BYTES times in a chain.
- The top level holds the registers, masking, bypass and counter.

## Test plan
- 8 lanes, Gen1. Beat: byte0 = FB(K), bytes 1-14 data, byte15 = FD(K). Expect `pl_tlpstart` = 64'h1, `pl_tlpend` = 64'h8000, `pl_valid` = 64'hFFFF.
- TLP spanning 3 beats:
  - Beat 1: FB(K) at byte0.
  - Beat 2: 32 data bytes. Expect `pl_valid` = 32'hFFFF_FFFF with no start/end flags.
  - Beat 3: FE(K) at byte3. Expect `pl_tlpedb` = 64'h8 and `pl_valid` = 64'hF.
- DLLP: SDP(K), 6 data, FD(K) in bytes 0-7. Expect `dlpstart` = 64'h1, `dlpend` = 64'h80, `pl_valid` = 64'hFF.
- Same DLLP with only 5 data bytes before END. Expect `pl_dlpend` = 0, `pl_err` bit 6 = 1, `err_count` = 1.
- 4 lanes (N = 16). A byte at position 20 = FB(K) is ignored: all flags 0.
- Reset asserted after a beat containing an STP; the next beat has END at byte2. Expect an error on byte2 and no `tlpend`.
- `gen` = 3'b010. Expect `data_out` = `data_in` delayed 1 cycle and all flags 0.
